rfwild_cnt_sequencer: RTL and testbench

//  Run controller for the RFWild 4-bit counter (contador_rfwild-style datapath).

---
 rtl/rfwild_cnt_sequencer_pkg.sv | 6 +
 rtl/rfwild_cnt_sequencer_if.sv | 28 ++
 rtl/rfwild_cnt_sequencer_gap_timer.sv | 17 +
 rtl/rfwild_cnt_sequencer.sv | 97 +++++++++
 tb/tb_rfwild_cnt_sequencer.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/rfwild_cnt_sequencer_pkg.sv
// rfwild_seq_pkg: state encoding and default widths shared by the RFWild counter sequencer files
package rfwild_seq_pkg;
    typedef enum logic [2:0] {IDLE, CLEAR, RUN, GAP, DONE, ERR} seq_state_t;
    localparam int CNT_W_DEF = 4;
    localparam int RUN_W_DEF = 4;
endpackage

// File: rtl/rfwild_cnt_sequencer_if.sv
// rfwild_cnt_sequencer_if: control request/status plus counter drive/readback of the sequencer
interface rfwild_cnt_sequencer_if
    import rfwild_seq_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int RUN_W = RUN_W_DEF
);
    logic             start;
    logic             stop;
    logic [CNT_W-1:0] tc_val;
    logic [RUN_W-1:0] n_runs;
    logic [CNT_W-1:0] cnt_in;
    logic             cnt_clr;
    logic             cnt_en;
    logic             busy;
    logic             done;
    logic             abort;
    logic [RUN_W-1:0] run_idx;
    logic             err;
    modport master (
        output start, stop, tc_val, n_runs, cnt_in,
        input  cnt_clr, cnt_en, busy, done, abort, run_idx, err
    );
    modport slave (
        input  start, stop, tc_val, n_runs, cnt_in,
        output cnt_clr, cnt_en, busy, done, abort, run_idx, err
    );
endinterface

// File: rtl/rfwild_cnt_sequencer_gap_timer.sv
// rfwild_seq_gap_timer: loadable down-counter timing the idle gap between runs
module rfwild_seq_gap_timer #(
    parameter int GAP_CYC = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic tick,
    output logic zero
);
    localparam int W = $clog2(GAP_CYC + 1);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge reset)
        if (!reset) cnt <= '0;
        else        cnt <= load ? W'(GAP_CYC - 1) : (tick && cnt != '0) ? cnt - 1'b1 : cnt;
    assign zero = cnt == '0;
endmodule

// File: rtl/rfwild_cnt_sequencer.sv
// rfwild_cnt_sequencer: sequences N clear/count/gap runs of the RFWild counter.
// Define RFWILD_SEQ_CHECK_EN to add the shadow-counter check and the ERR state.
module rfwild_cnt_sequencer
    import rfwild_seq_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int RUN_W   = RUN_W_DEF,
    parameter int GAP_CYC = 3
) (
    input logic                   clk,
    input logic                   reset,
    rfwild_cnt_sequencer_if.slave bus
);
    seq_state_t       state, state_nx;
    logic [CNT_W-1:0] tc_lat;
    logic [RUN_W-1:0] n_lat, run_idx_q;
    logic             abort_q, at_tc, last_run, mismatch;
    logic             gap_load, gap_tick, gap_zero;

    assign at_tc    = bus.cnt_in == tc_lat;
    assign last_run = (run_idx_q + RUN_W'(1)) == n_lat;

    always_comb begin
        state_nx = state;
        gap_load = 1'b0;
        gap_tick = 1'b0;
        unique case (state)
            IDLE:  state_nx = (bus.start && !bus.stop && bus.n_runs != '0) ? CLEAR : IDLE;
            CLEAR: state_nx = RUN;
            RUN: begin
                gap_load = at_tc && !last_run;
                state_nx = mismatch ? ERR : !at_tc ? RUN : last_run ? DONE : (GAP_CYC == 0) ? CLEAR : GAP;
            end
            GAP: begin
                gap_tick = 1'b1;
                state_nx = gap_zero ? CLEAR : GAP;
            end
            DONE:    state_nx = IDLE;
            ERR:     state_nx = ERR;
            default: state_nx = IDLE;
        endcase
        if (bus.stop && state != IDLE) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state     <= IDLE;
            tc_lat    <= '0;
            n_lat     <= '0;
            run_idx_q <= '0;
            abort_q   <= 1'b0;
        end else begin
            state   <= state_nx;
            abort_q <= bus.stop && state != IDLE;
            if (state == IDLE && state_nx == CLEAR) begin
                tc_lat    <= bus.tc_val;
                n_lat     <= bus.n_runs;
                run_idx_q <= '0;
            end else if (state == RUN && at_tc && !bus.stop && !mismatch) begin
                run_idx_q <= run_idx_q + 1'b1;
            end
        end

    generate
        if (GAP_CYC > 0) begin : g_gap
            rfwild_seq_gap_timer #(.GAP_CYC(GAP_CYC)) u_gap (
                .clk   (clk),
                .reset (reset),
                .load  (gap_load),
                .tick  (gap_tick),
                .zero  (gap_zero)
            );
        end else begin : g_nogap
            assign gap_zero = 1'b1;
        end
    endgenerate

`ifdef RFWILD_SEQ_CHECK_EN
    // Shadow copy of the counter; any readback disagreement in RUN traps into ERR
    logic [CNT_W-1:0] shadow;
    always_ff @(posedge clk or negedge reset)
        if (!reset) shadow <= '0;
        else        shadow <= bus.cnt_clr ? '0 : bus.cnt_en ? shadow + 1'b1 : shadow;
    assign mismatch = state == RUN && bus.cnt_in != shadow;
    assign bus.err  = state == ERR;
`else
    assign mismatch = 1'b0;
    assign bus.err  = 1'b0;
`endif

    assign bus.busy    = state != IDLE;
    assign bus.cnt_clr = state == CLEAR;
    assign bus.cnt_en  = state == RUN && !at_tc && !bus.stop && !mismatch;
    assign bus.done    = state == DONE && !bus.stop;
    assign bus.abort   = abort_q;
    assign bus.run_idx = run_idx_q;
endmodule

// File: tb/tb_rfwild_cnt_sequencer.sv
// tb_rfwild_cnt_sequencer: randomized sequences checked against a per-cycle expected trace
module tb_rfwild_cnt_sequencer;
    localparam int GAP = 3;

    typedef struct {
        bit busy;
        bit clr;
        bit en;
        bit done;
        bit abort;
        int idx;
        int cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] tb_cnt = 4'd0;
    logic       force_en = 1'b0;
    logic [3:0] force_val = 4'd0;
    int         n_tests = 0;
    int         n_fail = 0;

    rfwild_cnt_sequencer_if #(.CNT_W(4), .RUN_W(4)) bus ();

    rfwild_cnt_sequencer #(.CNT_W(4), .RUN_W(4), .GAP_CYC(GAP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural counter the sequencer drives; readback can be overridden
    always @(posedge clk)
        if (bus.cnt_clr)     tb_cnt <= 4'd0;
        else if (bus.cnt_en) tb_cnt <= tb_cnt + 4'd1;
    assign bus.cnt_in = force_en ? force_val : tb_cnt;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic check_entry(input exp_t e);
        check("busy", int'(bus.busy), int'(e.busy));
        check("cnt_clr", int'(bus.cnt_clr), int'(e.clr));
        check("cnt_en", int'(bus.cnt_en), int'(e.en));
        check("done", int'(bus.done), int'(e.done));
        check("abort", int'(bus.abort), int'(e.abort));
        check("run_idx", int'(bus.run_idx), e.idx);
        check("err", int'(bus.err), 0);
        if (e.cnt >= 0) check("cnt", int'(bus.cnt_in), e.cnt);
    endtask

    // s = index of the post-acceptance cycle holding stop high (-1: none)
    task automatic run_seq(input int tc, input int n, input int s, input bit rnd);
        exp_t q[$];
        exp_t e;
        int   ridx;
        int   last;
        ridx = 0;
        for (int r = 0; r < n; r++) begin
            e = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ridx, -1};
            q.push_back(e);
            for (int k = 0; k <= tc; k++) begin
                e = '{1'b1, 1'b0, k < tc, 1'b0, 1'b0, ridx, k};
                q.push_back(e);
            end
            ridx++;
            if (r < n - 1)
                for (int g = 0; g < GAP; g++) begin
                    e = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ridx, tc};
                    q.push_back(e);
                end
        end
        e = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, n, tc};
        q.push_back(e);
        if (s >= 0 && s < q.size()) begin
            while (q.size() > s + 1) void'(q.pop_back());
            q[s].en   = 1'b0;
            q[s].done = 1'b0;
            last = q[s].idx;
            e = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, last, -1};
            q.push_back(e);
            e.abort = 1'b0;
            q.push_back(e);
        end else begin
            e = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, n, tc};
            q.push_back(e);
            q.push_back(e);
        end
        @(negedge clk);
        bus.start  = 1'b1;
        bus.stop   = 1'b0;
        bus.tc_val = 4'(tc);
        bus.n_runs = 4'(n);
        #1 check("pre_busy", int'(bus.busy), 0);
        foreach (q[j]) begin
            @(negedge clk);
            bus.start  = (rnd && j < q.size() - 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.tc_val = 4'($urandom);
            bus.n_runs = 4'($urandom);
            bus.stop   = (j == s);
            #1 check_entry(q[j]);
        end
        bus.stop = 1'b0;
    endtask

    initial begin
        int tc;
        int n;
        int len;
        int s;
        bus.start  = 1'b0;
        bus.stop   = 1'b0;
        bus.tc_val = 4'd0;
        bus.n_runs = 4'd0;
        repeat (2) @(negedge clk);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_clr", int'(bus.cnt_clr), 0);
        check("rst_en", int'(bus.cnt_en), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_abort", int'(bus.abort), 0);
        check("rst_idx", int'(bus.run_idx), 0);
        check("rst_err", int'(bus.err), 0);
        reset = 1'b1;

        run_seq(5, 2, -1, 1'b0);
        run_seq(0, 1, -1, 1'b0);
        run_seq(15, 1, -1, 1'b0);
        run_seq(9, 3, 3, 1'b0);
        run_seq(7, 2, 1, 1'b1);

        // start with n_runs = 0 is ignored
        @(negedge clk);
        bus.start  = 1'b1;
        bus.n_runs = 4'd0;
        bus.tc_val = 4'd3;
        @(negedge clk);
        bus.start = 1'b0;
        #1 check("n0_busy", int'(bus.busy), 0);

        // start together with stop in IDLE is ignored and does not abort
        @(negedge clk);
        bus.start  = 1'b1;
        bus.stop   = 1'b1;
        bus.n_runs = 4'd3;
        @(negedge clk);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        #1 check("ss_busy", int'(bus.busy), 0);
        check("ss_abort", int'(bus.abort), 0);

        // reset in the middle of GAP
        @(negedge clk);
        bus.start  = 1'b1;
        bus.tc_val = 4'd2;
        bus.n_runs = 4'd2;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        #1 check("gap_busy", int'(bus.busy), 1);
        check("gap_idx", int'(bus.run_idx), 1);
        reset = 1'b0;
        #1 check("mr_busy", int'(bus.busy), 0);
        check("mr_clr", int'(bus.cnt_clr), 0);
        check("mr_en", int'(bus.cnt_en), 0);
        check("mr_done", int'(bus.done), 0);
        check("mr_abort", int'(bus.abort), 0);
        check("mr_idx", int'(bus.run_idx), 0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 25; i++) begin
            tc  = $urandom_range(0, 15);
            n   = $urandom_range(1, 15);
            len = n * (tc + 2) + (n - 1) * GAP + 1;
            s   = ($urandom_range(0, 2) == 0) ? $urandom_range(0, len - 1) : -1;
            run_seq(tc, n, s, 1'b1);
        end

`ifdef RFWILD_SEQ_CHECK_EN
        @(negedge clk);
        bus.start  = 1'b1;
        bus.tc_val = 4'd9;
        bus.n_runs = 4'd1;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        force_en  = 1'b1;
        force_val = 4'd7;
        #1 check("chk_en0", int'(bus.cnt_en), 0);
        @(negedge clk);
        force_en = 1'b0;
        #1 check("chk_err", int'(bus.err), 1);
        check("chk_busy", int'(bus.busy), 1);
        check("chk_en1", int'(bus.cnt_en), 0);
        @(negedge clk);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        #1 check("chk_abort", int'(bus.abort), 1);
        check("chk_errclr", int'(bus.err), 0);
        check("chk_idle", int'(bus.busy), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
